fractal_sync_rf_arb: RTL

FRACTAL_SYNC_RF_ARB -- requirements
Module: fractal_sync_rf_arb

---
 rtl/fractal_sync_rf_arb.sv | 116 +++++++++++
 1 files changed

// File: rtl/fractal_sync_rf_arb.sv
// Round-robin arbiter granting requesters onto N_PORTS register-file ports, one access per register per cycle.
// Grant is combinational (req_ready_o); the response is registered one cycle later and held until consumed.
module fractal_sync_rf_arb #(
  parameter int N_REQ     = 4,
  parameter int N_PORTS   = 2,
  parameter int N_REGS    = 3,
  parameter int IDX_WIDTH = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [N_REQ-1:0]                   req_valid_i,
  input  logic [N_REQ-1:0]                   req_op_i,
  input  logic [N_REQ-1:0][IDX_WIDTH-1:0]    req_idx_i,
  output logic [N_REQ-1:0]                   req_ready_o,
  output logic [N_REQ-1:0]                   resp_valid_o,
  output logic [N_REQ-1:0]                   resp_present_o,
  output logic [N_REQ-1:0]                   resp_err_o,
  input  logic [N_REQ-1:0]                   resp_ready_i,
  output logic [N_PORTS-1:0]                 check_o,
  output logic [N_PORTS-1:0]                 set_o,
  output logic [N_PORTS-1:0]                 idx_valid_o,
  output logic [N_PORTS-1:0][IDX_WIDTH-1:0]  idx_o,
  input  logic [N_PORTS-1:0]                 present_i
);

  localparam int RRW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int NIDX = 2 ** IDX_WIDTH;

  logic [RRW-1:0]            rr_q, rr_d;
  logic [N_REQ-1:0]          resp_valid_q, resp_present_q, resp_err_q;
  logic [N_REQ-1:0]          gnt, gnt_oor;
  logic [N_REQ-1:0][PW-1:0]  gnt_port;
  logic [NIDX-1:0]           idx_taken;
  logic [N_PORTS-1:0]        port_busy;
  logic [RRW-1:0]            cur;
  logic                      placed;
  int                        pos;

  // Scan from rr_q; grant decisions never look at present_i.
  always_comb begin
    gnt         = '0;
    gnt_oor     = '0;
    gnt_port    = '0;
    idx_taken   = '0;
    port_busy   = '0;
    rr_d        = rr_q;
    check_o     = '0;
    set_o       = '0;
    idx_valid_o = '0;
    idx_o       = '0;
    cur         = '0;
    placed      = 1'b0;
    pos         = 0;
    if (rst_ni) begin
      for (int k = 0; k < N_REQ; k++) begin
        pos    = int'(rr_q) + k;
        if (pos >= N_REQ) pos = pos - N_REQ;
        cur    = RRW'(pos);
        placed = 1'b0;
        if (req_valid_i[cur] && (!resp_valid_q[cur] || resp_ready_i[cur])) begin
          if (int'(req_idx_i[cur]) >= N_REGS) begin
            gnt[cur]     = 1'b1;
            gnt_oor[cur] = 1'b1;
            rr_d         = (pos == N_REQ - 1) ? '0 : RRW'(pos + 1);
          end else if (!idx_taken[req_idx_i[cur]]) begin
            for (int p = 0; p < N_PORTS; p++) begin
              if (!placed && !port_busy[p]) begin
                placed         = 1'b1;
                port_busy[p]   = 1'b1;
                gnt_port[cur]  = PW'(p);
                idx_valid_o[p] = 1'b1;
                idx_o[p]       = req_idx_i[cur];
                check_o[p]     = !req_op_i[cur];
                set_o[p]       = req_op_i[cur];
              end
            end
            if (placed) begin
              gnt[cur]                  = 1'b1;
              idx_taken[req_idx_i[cur]] = 1'b1;
              rr_d                      = (pos == N_REQ - 1) ? '0 : RRW'(pos + 1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q           <= '0;
      resp_valid_q   <= '0;
      resp_present_q <= '0;
      resp_err_q     <= '0;
    end else begin
      rr_q <= rr_d;
      for (int r = 0; r < N_REQ; r++) begin
        if (gnt[r]) begin
          resp_valid_q[r]   <= 1'b1;
          resp_present_q[r] <= !gnt_oor[r] && present_i[gnt_port[r]];
          resp_err_q[r]     <= gnt_oor[r];
        end else if (resp_ready_i[r]) begin
          resp_valid_q[r]   <= 1'b0;
          resp_present_q[r] <= 1'b0;
          resp_err_q[r]     <= 1'b0;
        end
      end
    end
  end

  assign req_ready_o    = gnt;
  assign resp_valid_o   = resp_valid_q;
  assign resp_present_o = resp_present_q;
  assign resp_err_o     = resp_err_q;

endmodule
